// File: rtl/penc_pkg.sv
// Shared types and helpers for the streaming priority-encoder block.
// Holds the FSM state enum, scan-order constants and width/popcount helpers.
package penc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam bit ORDER_MSB = 1'b1;
    localparam bit ORDER_LSB = 1'b0;

    localparam int POP_MAX_W = 1024;

    function automatic int clog2w(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            c = c + {31'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/penc_find_first.sv
// Combinational find-first-set over a vector, scanning from MSB or LSB.
// Returns the index, an any-set flag and a one-hot mask of the chosen bit.
module penc_find_first
    import penc_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = ORDER_MSB,
    localparam int IDX_W    = clog2w(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o,
    output logic [WIDTH-1:0] onehot_o
);

    always_comb begin
        idx_o    = '0;
        any_o    = 1'b0;
        onehot_o = '0;
        // Later hits overwrite earlier ones, so scan toward the winning end.
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec_i[i]) begin
                    idx_o       = IDX_W'(i);
                    any_o       = 1'b1;
                    onehot_o    = '0;
                    onehot_o[i] = 1'b1;
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec_i[i]) begin
                    idx_o       = IDX_W'(i);
                    any_o       = 1'b1;
                    onehot_o    = '0;
                    onehot_o[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/penc_scan_stream.sv
// Captures a request vector and streams the index of every set bit in priority order.
// Define PENC_COUNT_EN to add the out_count popcount port.
module penc_scan_stream
    import penc_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = ORDER_MSB,
    localparam int IDX_W    = clog2w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_none,
    output logic             out_last,
    output logic             out_valid,
`ifdef PENC_COUNT_EN
    output logic [IDX_W:0]   out_count,
`endif
    input  logic             out_ready
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             none_q, none_d;

    logic [IDX_W-1:0] ff_idx;
    logic             ff_any;
    logic [WIDTH-1:0] ff_onehot;
    logic             scan;
    logic             last;
    logic             accept;

    penc_find_first #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_ff (
        .vec_i    (pending_q),
        .idx_o    (ff_idx),
        .any_o    (ff_any),
        .onehot_o (ff_onehot)
    );

    assign scan   = (state_q == SCAN);
    assign last   = none_q | (ff_any & ~|(pending_q & ~ff_onehot));
    assign accept = in_valid & in_ready;

    assign in_ready  = (~scan | (out_ready & last)) & ~flush;
    assign out_valid = scan;
    assign out_idx   = scan ? ff_idx : '0;
    assign out_none  = scan & none_q;
    assign out_last  = scan & last;

`ifdef PENC_COUNT_EN
    logic [IDX_W:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (accept) begin
            count_d = (IDX_W+1)'(popcount(POP_MAX_W'(in_vec)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign out_count = count_q;
`endif

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        none_d    = none_q;
        if (flush) begin
            state_d   = IDLE;
            pending_d = '0;
            none_d    = 1'b0;
        end else if (accept) begin
            // Covers both the IDLE capture and the reload on a final beat.
            state_d   = SCAN;
            pending_d = in_vec;
            none_d    = (in_vec == '0);
        end else if (scan && out_ready) begin
            pending_d = pending_q & ~ff_onehot;
            if (last) begin
                state_d = IDLE;
                none_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            none_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            none_q    <= none_d;
        end
    end

endmodule

// File: tb/tb_penc_scan_stream.sv
// Directed bench for penc_scan_stream: MSB-first and LSB-first instances
// share the same stimulus; expected values are hand-derived constants.
module tb_penc_scan_stream;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] in_vec;
    logic        in_valid;
    logic        out_ready;

    logic        m_in_ready, m_none, m_last, m_valid;
    logic [3:0]  m_idx;
    logic        l_in_ready, l_none, l_last, l_valid;
    logic [3:0]  l_idx;
`ifdef PENC_COUNT_EN
    logic [4:0]  m_count;
    logic [4:0]  l_count;
`endif

    int checks = 0;
    int errors = 0;

    penc_scan_stream #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_ready  (m_in_ready),
        .out_idx   (m_idx),
        .out_none  (m_none),
        .out_last  (m_last),
        .out_valid (m_valid),
`ifdef PENC_COUNT_EN
        .out_count (m_count),
`endif
        .out_ready (out_ready)
    );

    penc_scan_stream #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_ready  (l_in_ready),
        .out_idx   (l_idx),
        .out_none  (l_none),
        .out_last  (l_last),
        .out_valid (l_valid),
`ifdef PENC_COUNT_EN
        .out_count (l_count),
`endif
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs of the MSB instance: valid, idx, last, none, in_ready.
    task automatic chk_m(input string tag, input logic v, input logic [3:0] i,
                         input logic la, input logic n, input logic r);
        chk({tag, ".valid"}, 32'(m_valid), 32'(v));
        chk({tag, ".idx"}, 32'(m_idx), 32'(i));
        chk({tag, ".last"}, 32'(m_last), 32'(la));
        chk({tag, ".none"}, 32'(m_none), 32'(n));
        chk({tag, ".in_ready"}, 32'(m_in_ready), 32'(r));
    endtask

    task automatic chk_l(input string tag, input logic v, input logic [3:0] i,
                         input logic la, input logic r);
        chk({tag, ".valid"}, 32'(l_valid), 32'(v));
        chk({tag, ".idx"}, 32'(l_idx), 32'(i));
        chk({tag, ".last"}, 32'(l_last), 32'(la));
        chk({tag, ".in_ready"}, 32'(l_in_ready), 32'(r));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_vec = '0; in_valid = 1'b0; out_ready = 1'b1;
        cyc(); cyc();
        settle();
        chk_m("rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk_l("rst_l", 1'b0, 4'd0, 1'b0, 1'b1);
`ifdef PENC_COUNT_EN
        chk("rst.count", 32'(m_count), 32'd0);
`endif
        rst = 1'b0;

        // 1: 0x8421 MSB first -> 15,10,5,0
        cyc(); in_vec = 16'h8421; in_valid = 1'b1; settle();
        chk_m("t1.idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(); in_valid = 1'b0; settle();
        chk_m("t1.b0", 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
`ifdef PENC_COUNT_EN
        chk("t1.count", 32'(m_count), 32'd4);
`endif
        cyc(); settle();
        chk_m("t1.b1", 1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
        cyc(); settle();
        chk_m("t1.b2", 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        cyc(); settle();
        chk_m("t1.b3", 1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
        cyc(); settle();
        chk_m("t1.end", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // 2: all-zero vector -> one none beat
        in_vec = 16'h0000; in_valid = 1'b1;
        cyc(); in_valid = 1'b0; settle();
        chk_m("t2.b0", 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
        chk_l("t2.b0l", 1'b1, 4'd0, 1'b1, 1'b1);
        cyc(); settle();
        chk_m("t2.end", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // 3: LSB first 0x8421 -> 0,5,10,15
        in_vec = 16'h8421; in_valid = 1'b1;
        cyc(); in_valid = 1'b0; settle();
        chk_l("t3.b0", 1'b1, 4'd0, 1'b0, 1'b0);
        cyc(); settle();
        chk_l("t3.b1", 1'b1, 4'd5, 1'b0, 1'b0);
        cyc(); settle();
        chk_l("t3.b2", 1'b1, 4'd10, 1'b0, 1'b0);
        cyc(); settle();
        chk_l("t3.b3", 1'b1, 4'd15, 1'b1, 1'b1);
        cyc(); settle();
        chk_l("t3.end", 1'b0, 4'd0, 1'b0, 1'b1);

        // 4: 0x00F0 with stall, then back-to-back 0x0003
        in_vec = 16'h00F0; in_valid = 1'b1;
        cyc(); in_valid = 1'b0; out_ready = 1'b0; settle();
        chk_m("t4.s0", 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        cyc(); settle();
        chk_m("t4.s1", 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        cyc(); out_ready = 1'b1; settle();
        chk_m("t4.s2", 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        cyc(); settle();
        chk_m("t4.b1", 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
        cyc(); settle();
        chk_m("t4.b2", 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        cyc(); in_vec = 16'h0003; in_valid = 1'b1; settle();
        chk_m("t4.b3", 1'b1, 4'd4, 1'b1, 1'b0, 1'b1);
        cyc(); in_valid = 1'b0; settle();
        chk_m("t4.r0", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        cyc(); settle();
        chk_m("t4.r1", 1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
        cyc(); settle();
        chk_m("t4.end", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // 5: flush on 2nd beat of 0xFFFF with a vector offered
        in_vec = 16'hFFFF; in_valid = 1'b1;
        cyc(); in_valid = 1'b0; settle();
        chk_m("t5.b0", 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
        cyc(); flush = 1'b1; in_vec = 16'h0003; in_valid = 1'b1; settle();
        chk_m("t5.fl", 1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
        cyc(); flush = 1'b0; in_valid = 1'b0; settle();
        chk_m("t5.idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
`ifdef PENC_COUNT_EN
        chk("t5.count", 32'(m_count), 32'd0);
`endif
        cyc(); settle();
        chk_m("t5.idle2", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // flush while idle is a no-op
        flush = 1'b1;
        cyc(); flush = 1'b0; settle();
        chk_m("t5.noop", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // 6: async reset mid-scan
        in_vec = 16'hFFFF; in_valid = 1'b1;
        cyc(); in_valid = 1'b0; settle();
`ifdef PENC_COUNT_EN
        chk("t6.count", 32'(m_count), 32'd16);
`endif
        cyc(); settle();
        chk_m("t6.b1", 1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_m("t6.rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
`ifdef PENC_COUNT_EN
        chk("t6.rcount", 32'(m_count), 32'd0);
`endif
        cyc(); rst = 1'b0;
        cyc(); in_vec = 16'h0001; in_valid = 1'b1;
        cyc(); in_valid = 1'b0; settle();
        chk_m("t6.after", 1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
        cyc(); settle();
        chk_m("t6.end", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
